// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch-to-decode path.
package rv32i_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_packet_t;

  localparam logic [31:0] RV32I_NOP = 32'h00000013;

endpackage

// File: rtl/rv32i_fetch_packet_fifo.sv
// In-order packet store with push/pop/clear; pointers wrap modulo DEPTH.
module rv32i_fetch_packet_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  fetch_packet_t wdata_i,
  output fetch_packet_t rdata_o,
  output logic [CW-1:0] count_o
);

  fetch_packet_t mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (pop_i && !push_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      // Storage is untouched by clear so the head payload just goes stale.
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv32i_decode_fetch_buffer.sv
// Decode-side fetch packet buffer with branch-miss flush and drop counter.
// Optional same-cycle bypass when empty: define DECODE_BUFFER_BYPASS_EN.
module rv32i_decode_fetch_buffer
  import rv32i_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_instruction_latch_en,
  input  logic [31:0]              i_fetch_instruction,
  input  logic [31:0]              i_fetch_instruction_pc,
  output logic                     o_decode_ready,
  input  logic                     i_branch_miss,
  output logic                     o_decode_valid,
  output logic [31:0]              o_decode_instruction,
  output logic [31:0]              o_decode_pc,
  input  logic                     i_decode_accept,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic [FLUSH_CNT_W-1:0]   o_flush_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [FLUSH_CNT_W-1:0] sat_add(input logic [FLUSH_CNT_W-1:0] a,
                                                     input logic [CW:0] b);
    logic [FLUSH_CNT_W:0] sum;
    sum = {1'b0, a} + (FLUSH_CNT_W+1)'(b);
    sat_add = sum[FLUSH_CNT_W] ? '1 : sum[FLUSH_CNT_W-1:0];
  endfunction

  logic [CW-1:0]          count;
  fetch_packet_t          head, wdata;
  logic                   ready, buf_valid, push, pop, accepted_in;
  logic [CW:0]            dropped;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  rv32i_fetch_packet_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (i_branch_miss),
    .wdata_i (wdata),
    .rdata_o (head),
    .count_o (count)
  );

  // Ready depends on registered occupancy only, never on accept or flush.
  assign ready       = (count < CW'(DEPTH));
  assign buf_valid   = (count != '0);
  assign accepted_in = i_instruction_latch_en & ready;
  assign wdata       = '{pc: i_fetch_instruction_pc, instruction: i_fetch_instruction};
  assign pop         = buf_valid & i_decode_accept & ~i_branch_miss;

`ifdef DECODE_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass               = ~buf_valid & i_instruction_latch_en & ~i_branch_miss;
  assign o_decode_valid       = buf_valid | bypass;
  assign o_decode_instruction = bypass ? wdata.instruction : head.instruction;
  assign o_decode_pc          = bypass ? wdata.pc : head.pc;
  // A bypassed packet taken in the same cycle is never written.
  assign push = accepted_in & ~i_branch_miss & ~(bypass & i_decode_accept);
`else
  assign o_decode_valid       = buf_valid;
  assign o_decode_instruction = head.instruction;
  assign o_decode_pc          = head.pc;
  assign push                 = accepted_in & ~i_branch_miss;
`endif

  assign dropped     = {1'b0, count} + (CW+1)'(accepted_in);
  assign flush_cnt_d = i_branch_miss ? sat_add(flush_cnt_q, dropped) : flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) flush_cnt_q <= '0;
    else          flush_cnt_q <= flush_cnt_d;
  end

  assign o_decode_ready = ready;
  assign o_occupancy    = count;
  assign o_flush_count  = flush_cnt_q;

endmodule
